// File: rtl/latch_ex_mem_skid_pkg.sv
// Shared definitions for the EX->MEM pipeline latch: default widths,
// memory op codes and the occupancy state decoded from the slot valid bits.
package latch_ex_mem_skid_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_MEM_OP_W   = 4;

  // Memory op codes; zero means the entry does not touch data memory
  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LH   = 4'd2;
  localparam logic [3:0] MEM_OP_LW   = 4'd3;
  localparam logic [3:0] MEM_OP_LBU  = 4'd4;
  localparam logic [3:0] MEM_OP_LHU  = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  // Occupancy is {main_v, skid_v}; 2'b01 can never occur in normal operation
  typedef enum logic [1:0] {
    LATCH_EMPTY = 2'b00,
    LATCH_ONE   = 2'b10,
    LATCH_TWO   = 2'b11
  } latch_state_e;

  function automatic latch_state_e latch_state(input logic main_v, input logic skid_v);
    return latch_state_e'({main_v, skid_v});
  endfunction

endpackage

// File: rtl/latch_ex_mem_skid_slot.sv
// One storage slot of the EX->MEM latch: a payload register with its valid
// bit. The payload is forced to zero whenever the slot is empty so that a
// bubble never carries stale fields downstream.
module latch_ex_mem_skid_slot
  import latch_ex_mem_skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a squash drops any entry arriving the same cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/latch_ex_mem_skid.sv
// EX->MEM pipeline latch with valid/ready handshake and a two-entry skid
// buffer. The main slot drives the MEM outputs; the skid slot catches the
// entry EX launched while MEM was stalling. ex_ready depends only on the
// registered skid valid bit, so mem_ready never reaches ex_ready through logic.
module latch_ex_mem_skid
  import latch_ex_mem_skid_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MEM_OP_W   = DEFAULT_MEM_OP_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_register_write_enable,
  input  logic [REG_ADDR_W-1:0] ex_register_write_address,
  input  logic [DATA_WIDTH-1:0] ex_register_write_data,
  input  logic [MEM_OP_W-1:0]   ex_mem_op,
  input  logic [DATA_WIDTH-1:0] ex_mem_address,
  input  logic [DATA_WIDTH-1:0] ex_mem_store_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_register_write_enable,
  output logic [REG_ADDR_W-1:0] mem_register_write_address,
  output logic [DATA_WIDTH-1:0] mem_register_write_data,
  output logic [MEM_OP_W-1:0]   mem_mem_op,
  output logic [DATA_WIDTH-1:0] mem_mem_address,
  output logic [DATA_WIDTH-1:0] mem_mem_store_data
);

  localparam int PAYLOAD_W = 1 + REG_ADDR_W + 3 * DATA_WIDTH + MEM_OP_W;

  logic                 main_v;
  logic                 skid_v;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic [PAYLOAD_W-1:0] main_d;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic                 accept;
  logic                 consume;
  logic                 main_load;
  logic                 main_clear;
  logic                 main_from_skid;
  logic                 skid_load;
  logic                 skid_clear;
  latch_state_e         state;

  assign ex_payload = {ex_register_write_enable, ex_register_write_address,
                       ex_register_write_data, ex_mem_op,
                       ex_mem_address, ex_mem_store_data};

  assign state    = latch_state(main_v, skid_v);
  assign ex_ready = !skid_v;
  assign accept   = ex_valid & ex_ready;
  assign consume  = main_v & mem_ready;

  // Slot control: decide which slot loads or empties from occupancy and handshakes
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    case (state)
      LATCH_EMPTY: begin
        if (accept) main_load = 1'b1;
      end
      LATCH_ONE: begin
        if (accept && consume)  main_load  = 1'b1;
        else if (accept)        skid_load  = 1'b1;
        else if (consume)       main_clear = 1'b1;
      end
      LATCH_TWO: begin
        if (consume) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
      end
      default: begin
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end
    endcase
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  assign main_d = main_from_skid ? skid_q : ex_payload;

  latch_ex_mem_skid_slot #(.WIDTH(PAYLOAD_W)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  latch_ex_mem_skid_slot #(.WIDTH(PAYLOAD_W)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (ex_payload),
    .valid (skid_v),
    .q     (skid_q)
  );

  assign mem_valid = main_v;
  assign {mem_register_write_enable, mem_register_write_address,
          mem_register_write_data, mem_mem_op,
          mem_mem_address, mem_mem_store_data} = main_q;

endmodule

// File: tb/tb_latch_ex_mem_skid.sv
// Bench for the EX->MEM skid latch. Directed stimulus pushes every entry it
// expects to emerge into a queue; a monitor pops and compares each entry MEM
// consumes, and checks that bubbles carry an all-zero payload.
module tb_latch_ex_mem_skid;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 4;
  localparam int PW = 1 + AW + 3 * DW + OW;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic          ex_we;
  logic [AW-1:0] ex_wa;
  logic [DW-1:0] ex_wd;
  logic [OW-1:0] ex_op;
  logic [DW-1:0] ex_addr;
  logic [DW-1:0] ex_sd;
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [OW-1:0] mem_op;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_sd;
  logic [PW-1:0] mem_payload;

  int            errors = 0;
  int            checks = 0;
  bit            monitor_en = 1'b0;
  logic [PW-1:0] expected_q[$];

  latch_ex_mem_skid #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .MEM_OP_W(OW)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .flush                      (flush),
    .ex_valid                   (ex_valid),
    .ex_ready                   (ex_ready),
    .ex_register_write_enable   (ex_we),
    .ex_register_write_address  (ex_wa),
    .ex_register_write_data     (ex_wd),
    .ex_mem_op                  (ex_op),
    .ex_mem_address             (ex_addr),
    .ex_mem_store_data          (ex_sd),
    .mem_valid                  (mem_valid),
    .mem_ready                  (mem_ready),
    .mem_register_write_enable  (mem_we),
    .mem_register_write_address (mem_wa),
    .mem_register_write_data    (mem_wd),
    .mem_mem_op                 (mem_op),
    .mem_mem_address            (mem_addr),
    .mem_mem_store_data         (mem_sd)
  );

  assign mem_payload = {mem_we, mem_wa, mem_wd, mem_op, mem_addr, mem_sd};

  always #5 clock = ~clock;

  // Entry with every field derived from n so misrouted fields stand out
  function automatic logic [PW-1:0] make_entry(input logic [DW-1:0] n);
    logic [DW-1:0] a;
    a = 32'h0000_1000 + n;
    return {1'b1, 5'd3, n, n[3:0], a, ~n};
  endfunction

  task automatic apply_stimulus(input bit v, input logic [PW-1:0] e);
    ex_valid = v;
    {ex_we, ex_wa, ex_wd, ex_op, ex_addr, ex_sd} = e;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: sample mid-cycle what MEM will consume at the next edge
  always @(negedge clock) begin
    if (monitor_en && reset && !flush) begin
      if (mem_valid && mem_ready) begin
        if (expected_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_unexpected: got %0h expected nothing", mem_payload);
        end else begin
          check_output("scoreboard", mem_payload, expected_q.pop_front());
        end
      end else if (!mem_valid) begin
        check_output("bubble_payload", mem_payload, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two cycles while EX keeps offering an entry
    reset = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    apply_stimulus(1'b1, make_entry(32'd99));
    step();
    step();
    check_output("reset_mem_valid", mem_valid, 0);
    check_output("reset_payload", mem_payload, 0);
    check_output("reset_ex_ready", ex_ready, 1);
    apply_stimulus(1'b0, '0);
    reset = 1'b1;
    step();
    check_output("post_reset_mem_valid", mem_valid, 0);
    check_output("post_reset_ex_ready", ex_ready, 1);
    monitor_en = 1'b1;

    // Streaming: eight entries back to back with MEM always ready
    mem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, make_entry(i));
      expected_q.push_back(make_entry(i));
      step();
      check_output("stream_valid", mem_valid, 1);
      check_output("stream_payload", mem_payload, make_entry(i));
      check_output("stream_ex_ready", ex_ready, 1);
    end
    apply_stimulus(1'b0, '0);
    step();
    check_output("stream_drained", mem_valid, 0);

    // Back-pressure: A and B fill both slots, C waits at EX
    mem_ready = 1'b0;
    apply_stimulus(1'b1, make_entry(32'h11));
    expected_q.push_back(make_entry(32'h11));
    step();
    check_output("bp_one_ex_ready", ex_ready, 1);
    apply_stimulus(1'b1, make_entry(32'h22));
    expected_q.push_back(make_entry(32'h22));
    step();
    check_output("bp_two_ex_ready", ex_ready, 0);
    check_output("bp_two_head", mem_payload, make_entry(32'h11));
    apply_stimulus(1'b1, make_entry(32'h33));
    step();
    check_output("bp_hold_ex_ready", ex_ready, 0);
    check_output("bp_hold_head", mem_payload, make_entry(32'h11));
    mem_ready = 1'b1;
    step();
    check_output("bp_release_head", mem_payload, make_entry(32'h22));
    check_output("bp_release_ex_ready", ex_ready, 1);
    expected_q.push_back(make_entry(32'h33));
    step();
    check_output("bp_c_head", mem_payload, make_entry(32'h33));
    apply_stimulus(1'b0, '0);
    step();
    check_output("bp_drained", mem_valid, 0);

    // Flush in TWO with an incoming entry and MEM ready: everything dropped
    mem_ready = 1'b0;
    apply_stimulus(1'b1, make_entry(32'h44));
    step();
    apply_stimulus(1'b1, make_entry(32'h55));
    step();
    check_output("flush_setup_two", ex_ready, 0);
    flush = 1'b1;
    mem_ready = 1'b1;
    apply_stimulus(1'b1, make_entry(32'h66));
    step();
    check_output("flush_mem_valid", mem_valid, 0);
    check_output("flush_we", mem_we, 0);
    check_output("flush_ex_ready", ex_ready, 1);
    check_output("flush_payload", mem_payload, 0);
    flush = 1'b0;
    apply_stimulus(1'b0, '0);
    step();
    check_output("flush_dropped", mem_valid, 0);

    // Reset together with flush while in TWO: nothing stale may emerge later
    mem_ready = 1'b0;
    apply_stimulus(1'b1, make_entry(32'h77));
    step();
    apply_stimulus(1'b1, make_entry(32'h88));
    step();
    check_output("midreset_setup_two", ex_ready, 0);
    reset = 1'b0;
    flush = 1'b1;
    apply_stimulus(1'b0, '0);
    step();
    check_output("midreset_mem_valid", mem_valid, 0);
    check_output("midreset_payload", mem_payload, 0);
    check_output("midreset_ex_ready", ex_ready, 1);
    reset = 1'b1;
    flush = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("midreset_no_stale", mem_valid, 0);
    end

    // Accept and consume together in ONE: main replaced, skid stays empty
    apply_stimulus(1'b1, make_entry(32'h99));
    expected_q.push_back(make_entry(32'h99));
    step();
    check_output("ac_first_head", mem_payload, make_entry(32'h99));
    apply_stimulus(1'b1, make_entry(32'hAA));
    expected_q.push_back(make_entry(32'hAA));
    step();
    check_output("ac_replaced_head", mem_payload, make_entry(32'hAA));
    check_output("ac_ex_ready", ex_ready, 1);
    apply_stimulus(1'b0, '0);
    step();
    check_output("ac_drained", mem_valid, 0);

    step();
    check_output("scoreboard_empty", expected_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
